// File: rtl/sparc_mem_pkg.sv
// ---------------------------------------------------------------------------
// sparc_mem_pkg
//   Shared encodings for the SPARC data memory: access-size codes, the
//   request FSM state type and default address/data widths.
// ---------------------------------------------------------------------------
package sparc_mem_pkg;

   localparam int DEF_ADDR_W = 9;
   localparam int DEF_DATA_W = 32;

   // req_size encodings
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/mem_lane_format.sv
// ---------------------------------------------------------------------------
// mem_lane_format
//   Combinational alignment check and load-data formatting.
//   Ports:
//     size_i    access size code
//     addr_lo_i low two bits of the byte address
//     signed_i  sign-extend narrow loads when set
//     we_i      store request (forces rdata_o to 0)
//     raw_i     {Mem[A], Mem[A+1], Mem[A+2], Mem[A+3]}, big-endian
//     err_o     misaligned or reserved-size request
//     rdata_o   right-justified, extended load data; 0 on store or error
// ---------------------------------------------------------------------------
module mem_lane_format
   import sparc_mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        signed_i,
   input  logic        we_i,
   input  logic [31:0] raw_i,
   output logic        err_o,
   output logic [31:0] rdata_o
);

   logic ext;

   always_comb begin
      err_o = 1'b0;
      unique case (size_i)
         SZ_BYTE: err_o = 1'b0;
         SZ_HALF: err_o = addr_lo_i[0];
         SZ_WORD: err_o = |addr_lo_i;
         default: err_o = 1'b1;
      endcase
   end

   // Mem[A] lands in raw_i[31:24], so it is the MSB of every narrow load.
   assign ext = signed_i & raw_i[31];

   always_comb begin
      rdata_o = '0;
      if (!we_i && !err_o) begin
         unique case (size_i)
            SZ_BYTE: rdata_o = {{24{ext}}, raw_i[31:24]};
            SZ_HALF: rdata_o = {{16{ext}}, raw_i[31:16]};
            SZ_WORD: rdata_o = raw_i;
            default: rdata_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/ram_512x8.sv
// ---------------------------------------------------------------------------
// ram_512x8
//   Byte-addressed 512x8 big-endian data memory serving MEM-stage load/store
//   requests over valid/ready. One request in flight: IDLE -> BUSY -> RESP.
//   Ports:
//     clk, rst_n            clock, async active-low reset (array not reset)
//     req_valid/req_ready   request handshake (ready only in IDLE)
//     req_we                1 = store, 0 = load
//     req_size              00 byte, 01 half, 10 word, 11 reserved
//     req_signed            sign-extend narrow loads
//     req_addr, req_wdata   byte address, right-justified store data
//     rsp_valid/rsp_ready   response handshake
//     rsp_rdata, rsp_err    load data (0 for stores/errors), error flag
// ---------------------------------------------------------------------------
module ram_512x8
   import sparc_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = 512,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   // Storage; left unreset so contents survive rst_n and can be preloaded.
   logic [7:0] Mem [0:DEPTH-1];

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              we_q, we_d;
   logic              sgn_q, sgn_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [ADDR_W-1:0] a1, a2, a3;
   logic [31:0]       raw;
   logic              fmt_err;
   logic [31:0]       fmt_rdata;
   logic              wr_en;

   // Aligned accesses never cross the top of the array; the natural
   // ADDR_W-bit wrap only matters for bytes that are then discarded.
   assign a1  = addr_q + ADDR_W'(1);
   assign a2  = addr_q + ADDR_W'(2);
   assign a3  = addr_q + ADDR_W'(3);
   assign raw = {Mem[addr_q], Mem[a1], Mem[a2], Mem[a3]};

   mem_lane_format u_fmt (
      .size_i    (size_q),
      .addr_lo_i (addr_q[1:0]),
      .signed_i  (sgn_q),
      .we_i      (we_q),
      .raw_i     (raw),
      .err_o     (fmt_err),
      .rdata_o   (fmt_rdata)
   );

   // Store commits on the edge leaving BUSY. A reset during BUSY forces
   // state_q back to IDLE asynchronously, so the write is dropped.
   assign wr_en = (state_q == ST_BUSY) && we_q && !fmt_err;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         unique case (size_q)
            SZ_BYTE: Mem[addr_q] <= wdata_q[7:0];
            SZ_HALF: begin
               Mem[addr_q] <= wdata_q[15:8];
               Mem[a1]     <= wdata_q[7:0];
            end
            SZ_WORD: begin
               Mem[addr_q] <= wdata_q[31:24];
               Mem[a1]     <= wdata_q[23:16];
               Mem[a2]     <= wdata_q[15:8];
               Mem[a3]     <= wdata_q[7:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         size_q  <= SZ_BYTE;
         we_q    <= 1'b0;
         sgn_q   <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         we_q    <= we_d;
         sgn_q   <= sgn_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      we_d    = we_q;
      sgn_d   = sgn_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               size_d  = req_size;
               we_d    = req_we;
               sgn_d   = req_signed;
               wdata_d = req_wdata;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            rdata_d = DATA_W'(fmt_rdata);
            err_d   = fmt_err;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_ram_512x8.sv
module tb_ram_512x8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [8:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_512x8 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %08h exp %08h", tag, obs, exp);
      end
   endtask

   // Present a request, wait for acceptance, then scramble req_* during BUSY
   // to show only the accepted values matter. Returns at the BUSY negedge.
   task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [8:0] a, input logic [31:0] wd);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 32'(n < 20), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_signed = ~sg;
      req_addr = ~a; req_wdata = ~wd;
      chk("busy_vld", 32'(rsp_valid), 32'd0);
      chk("busy_rdy", 32'(req_ready), 32'd0);
   endtask

   // Response must be valid one edge after BUSY (two after acceptance).
   task automatic take_rsp(output logic [31:0] rd, output logic er);
      @(negedge clk);
      chk("latency", 32'(rsp_valid), 32'd1);
      rd = rsp_rdata;
      er = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("back_idle", 32'(req_ready), 32'd1);
   endtask

   task automatic xfer(input string tag, input logic we, input logic [1:0] sz,
                       input logic sg, input logic [8:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_er);
      logic [31:0] rd;
      logic        er;
      issue(we, sz, sg, a, wd);
      take_rsp(rd, er);
      chk({tag, "_rdata"}, rd, exp_rd);
      chk({tag, "_err"}, 32'(er), 32'(exp_er));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   initial begin
      // Preload Mem[i] = i[7:0]
      for (int i = 0; i < 512; i++) dut.Mem[i] = 8'(i);

      // Reset state
      #12;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_vld",   32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err",   32'(rsp_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Word store / load, big-endian lanes
      xfer("st_w8", 1'b1, 2'b10, 1'b0, 9'd8, 32'hDEADBEEF, 32'h0, 1'b0);
      chk("m8",  32'(dut.Mem[8]),  32'hDE);
      chk("m9",  32'(dut.Mem[9]),  32'hAD);
      chk("m10", 32'(dut.Mem[10]), 32'hBE);
      chk("m11", 32'(dut.Mem[11]), 32'hEF);
      xfer("ld_w8", 1'b0, 2'b10, 1'b0, 9'd8, 32'h0, 32'hDEADBEEF, 1'b0);
      xfer("ld_w8s", 1'b0, 2'b10, 1'b1, 9'd8, 32'h0, 32'hDEADBEEF, 1'b0);

      // Byte store, signed/unsigned loads, neighbours untouched
      xfer("st_b13", 1'b1, 2'b00, 1'b0, 9'd13, 32'h12345680, 32'h0, 1'b0);
      xfer("ld_b13s", 1'b0, 2'b00, 1'b1, 9'd13, 32'h0, 32'hFFFFFF80, 1'b0);
      xfer("ld_b13u", 1'b0, 2'b00, 1'b0, 9'd13, 32'h0, 32'h00000080, 1'b0);
      chk("m12", 32'(dut.Mem[12]), 32'h0C);
      chk("m14", 32'(dut.Mem[14]), 32'h0E);

      // Halfword store / loads
      xfer("st_h6", 1'b1, 2'b01, 1'b0, 9'd6, 32'hAAAA1234, 32'h0, 1'b0);
      xfer("ld_h6s", 1'b0, 2'b01, 1'b1, 9'd6, 32'h0, 32'h00001234, 1'b0);
      xfer("ld_w4", 1'b0, 2'b10, 1'b0, 9'd4, 32'h0, 32'h04051234, 1'b0);
      xfer("st_h2", 1'b1, 2'b01, 1'b0, 9'd2, 32'h0000F00D, 32'h0, 1'b0);
      xfer("ld_h2s", 1'b0, 2'b01, 1'b1, 9'd2, 32'h0, 32'hFFFFF00D, 1'b0);
      xfer("ld_h2u", 1'b0, 2'b01, 1'b0, 9'd2, 32'h0, 32'h0000F00D, 1'b0);
      xfer("ld_b511", 1'b0, 2'b00, 1'b1, 9'd511, 32'h0, 32'hFFFFFFFF, 1'b0);

      // Misaligned and reserved-size requests
      xfer("st_w5", 1'b1, 2'b10, 1'b0, 9'd5, 32'h11223344, 32'h0, 1'b1);
      chk("m5_keep", 32'(dut.Mem[5]), 32'h05);
      chk("m6_keep", 32'(dut.Mem[6]), 32'h12);
      chk("m8_keep", 32'(dut.Mem[8]), 32'hDE);
      xfer("ld_h3", 1'b0, 2'b01, 1'b1, 9'd3, 32'h0, 32'h0, 1'b1);
      xfer("ld_rsvd", 1'b0, 2'b11, 1'b0, 9'd0, 32'h0, 32'h0, 1'b1);
      xfer("st_rsvd", 1'b1, 2'b11, 1'b0, 9'd0, 32'h000000FF, 32'h0, 1'b1);
      chk("m0_keep", 32'(dut.Mem[0]), 32'h00);

      // Backpressure: response held while a new request waits
      issue(1'b0, 2'b10, 1'b0, 9'd8, 32'h0);
      @(negedge clk);
      chk("bp_lat", 32'(rsp_valid), 32'd1);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b1;
      req_addr = 9'd13; req_wdata = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_vld",   32'(rsp_valid), 32'd1);
         chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
         chk("bp_rdy",   32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp_drop", 32'(rsp_valid), 32'd0);
      chk("bp_idle", 32'(req_ready), 32'd1);
      @(negedge clk);
      chk("bp_acc", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
      chk("bp2_vld", 32'(rsp_valid), 32'd1);
      chk("bp2_rdata", rsp_rdata, 32'hFFFFFF80);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // Reset while a response is held
      issue(1'b0, 2'b10, 1'b0, 9'd8, 32'h0);
      @(negedge clk);
      chk("rr_vld_pre", 32'(rsp_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rr_vld",   32'(rsp_valid), 32'd0);
      chk("rr_err",   32'(rsp_err), 32'd0);
      chk("rr_rdata", rsp_rdata, 32'd0);
      chk("rr_rdy",   32'(req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset during BUSY aborts the store; array persists across reset
      issue(1'b1, 2'b10, 1'b0, 9'd8, 32'h00000000);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_m8",  32'(dut.Mem[8]),  32'hDE);
      chk("abort_m11", 32'(dut.Mem[11]), 32'hEF);
      chk("abort_vld", 32'(rsp_valid), 32'd0);
      xfer("ld_w8_post", 1'b0, 2'b10, 1'b0, 9'd8, 32'h0, 32'hDEADBEEF, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
